// File: rtl/song_pkg.sv
// rtl/song_pkg.sv - shared state type and default sizes for the song sequencer and song memory
package song_pkg;
    localparam int SONG_LEN = 26;
    localparam int LOC_W    = 5;
    localparam int DUR_W    = 26;
    localparam int NOTE_W   = 4;

    typedef enum logic [2:0] {IDLE, FETCH, PLAY, GAP, DONE} state_e;
endpackage

// File: rtl/song_player_note_timer.sv
// rtl/song_player_note_timer.sv - loadable down-counter shared by note playback and the silent gap
module note_timer #(
    parameter int W = song_pkg::DUR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         clear,
    output logic         expire
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry is flagged on the last counted cycle so the owner can switch phase on that same edge.
    assign expire = (cnt_q == W'(1));
endmodule

// File: rtl/song_player.sv
// rtl/song_player.sv - walks one stored song, fetching note/duration and driving tone then gap
module song_player #(
    parameter int SONG_LEN      = song_pkg::SONG_LEN,
    parameter int LOC_W         = song_pkg::LOC_W,
    parameter int DUR_W         = song_pkg::DUR_W,
    parameter int GAP_CYCLES    = 5000000,
    parameter int FETCH_TIMEOUT = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        repeat_en,
    input  logic [1:0]                  songnum_sel,
    output logic                        mem_isread,
    output logic [1:0]                  mem_songnum,
    output logic [LOC_W-1:0]            mem_location,
    input  logic [song_pkg::NOTE_W-1:0] mem_note,
    input  logic [DUR_W-1:0]            mem_duration,
    input  logic                        mem_isvalid,
    output logic [song_pkg::NOTE_W-1:0] note_out,
    output logic                        note_active,
    output logic                        busy,
    output logic                        done,
    output logic                        error
);
    import song_pkg::*;

    localparam int FC_W = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [DUR_W-1:0] GAP_V    = DUR_W'(GAP_CYCLES);
    localparam logic [LOC_W-1:0] LAST_LOC = LOC_W'(SONG_LEN - 1);

    state_e              state_q, state_d;
    logic [LOC_W-1:0]    loc_q, loc_d;
    logic [1:0]          song_q, song_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic                err_q, err_d;
    logic [FC_W-1:0]     fcnt_q, fcnt_d;
    logic                busy_q, rd_q, act_q, done_q;
    logic                tmr_load, tmr_clear, tmr_expire;
    logic [DUR_W-1:0]    tmr_val;

    note_timer #(.W(DUR_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmr_load),
        .value  (tmr_val),
        .clear  (tmr_clear),
        .expire (tmr_expire)
    );

    always_comb begin
        state_d   = state_q;
        loc_d     = loc_q;
        song_d    = song_q;
        note_d    = note_q;
        err_d     = err_q;
        fcnt_d    = fcnt_q;
        tmr_load  = 1'b0;
        tmr_val   = mem_duration;
        tmr_clear = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !stop && songnum_sel != 2'd0) begin
                    state_d = FETCH;
                    song_d  = songnum_sel;
                    loc_d   = '0;
                    err_d   = 1'b0;
                    fcnt_d  = '0;
                end
            end
            FETCH: begin
                if (mem_isvalid) begin
                    note_d = mem_note;
                    if (mem_duration == '0) begin
                        state_d = DONE;
                    end else begin
                        tmr_load = 1'b1;
                        state_d  = PLAY;
                    end
                end else if (fcnt_q == FC_W'(FETCH_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    fcnt_d = fcnt_q + FC_W'(1);
                end
            end
            PLAY: begin
                if (tmr_expire) begin
                    tmr_load = 1'b1;
                    tmr_val  = GAP_V;
                    state_d  = GAP;
                end
            end
            GAP: begin
                if (tmr_expire) begin
                    fcnt_d = '0;
                    if (loc_q != LAST_LOC) begin
                        loc_d   = loc_q + LOC_W'(1);
                        state_d = FETCH;
                    end else if (repeat_en) begin
                        loc_d   = '0;
                        state_d = FETCH;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // DONE already ends the song, so a stop there simply lets it return to IDLE.
        if (stop && state_q != IDLE && state_q != DONE) begin
            state_d = DONE;
        end
        if (state_d == DONE) begin
            note_d    = '0;
            song_d    = '0;
            tmr_clear = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            loc_q   <= '0;
            song_q  <= '0;
            note_q  <= '0;
            err_q   <= 1'b0;
            fcnt_q  <= '0;
            busy_q  <= 1'b0;
            rd_q    <= 1'b0;
            act_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            loc_q   <= loc_d;
            song_q  <= song_d;
            note_q  <= note_d;
            err_q   <= err_d;
            fcnt_q  <= fcnt_d;
            busy_q  <= (state_d != IDLE);
            rd_q    <= (state_d == FETCH);
            act_q   <= (state_d == PLAY);
            done_q  <= (state_d == DONE);
        end
    end

    // stop silences the buzzer and the memory read in the very cycle it is seen.
    assign mem_isread   = rd_q & ~stop;
    assign note_active  = act_q & ~stop;
    assign mem_songnum  = song_q;
    assign mem_location = loc_q;
    assign note_out     = note_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = err_q;
endmodule
